// File: rtl/cfg_report_gen.sv
// Config readback report: serialises the GC list and PGM/FSM/SSM config into one FAST packet.
// Define CFG_REPORT_CSUM_EN to add an XOR checksum word ahead of the SSM tail word.
module cfg_report_gen #(
  parameter string PLATFORM  = "xilinx",
  parameter int    GCL_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_rpt_req,
  input  logic [3:0]    in_rpt_seq,
  input  logic          in_alf,
  output logic [133:0]  out_rpt_data,
  output logic          out_rpt_data_wr,
  output logic          out_rpt_busy,
  output logic          out_rpt_done,
  output logic          out_gc_rd,
  output logic [4:0]    out_gc_addr,
  input  logic [127:0]  in_gc_q,
  input  logic          in_test_stop,
  input  logic [19:0]   in_slot_cycle,
  input  logic [255:0]  in_tb_cfg,
  input  logic [95:0]   in_pkt_len,
  input  logic [1663:0] in_rule_mask,
  input  logic [15:0]   in_samp_freq
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_GCL_RD, S_GCL_WR, S_CFG, S_DONE} state_t;

  localparam logic [5:0] HDR_LAST     = 6'd3;
  localparam logic [5:0] RM_FIRST     = 6'd42;
  localparam logic [5:0] RM_LAST      = 6'd57;
  localparam logic [4:0] GC_LAST_ADDR = 5'(GCL_DEPTH - 1);
`ifdef CFG_REPORT_CSUM_EN
  localparam logic [5:0] GC_FIRST  = 6'd4;
  localparam logic [5:0] CSUM_IDX  = 6'd59;
  localparam logic [5:0] LAST_IDX  = 6'd60;
  localparam logic       CSUM_FLAG = 1'b1;
`else
  localparam logic [5:0] LAST_IDX  = 6'd59;
  localparam logic       CSUM_FLAG = 1'b0;
`endif

  // Vendor hook: both targets currently share the same generic logic.
  if (PLATFORM == "xilinx") begin : g_vendor_xilinx
  end else begin : g_vendor_generic
  end

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [4:0]   addr_q, addr_d;
  logic         cap_vld_q, cap_vld_d;
  logic [3:0]   seq_q;
  logic [127:0] cap_q;
  logic [127:0] payload;
  logic [1:0]   word_type;
  logic [3:0]   rm_sel;
  logic [10:0]  rm_base;
  logic         wr;
`ifdef CFG_REPORT_CSUM_EN
  logic [127:0] csum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      cap_vld_q <= cap_vld_d;
    end
  end

  // A stalled GC word is captured once, since in_gc_q is only valid the cycle after the read.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_rpt_req) seq_q <= in_rpt_seq;
    if (state_q == S_GCL_WR && in_alf && !cap_vld_q) cap_q <= in_gc_q;
  end

`ifdef CFG_REPORT_CSUM_EN
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      csum_q <= '0;
    end else if (wr && cnt_q >= GC_FIRST && cnt_q < CSUM_IDX) begin
      csum_q <= csum_q ^ payload;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cap_vld_d = cap_vld_q;
    case (state_q)
      S_IDLE: begin
        if (in_rpt_req) begin
          state_d   = S_HDR;
          cnt_d     = '0;
          addr_d    = '0;
          cap_vld_d = 1'b0;
        end
      end
      S_HDR: begin
        if (!in_alf) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == HDR_LAST) state_d = S_GCL_RD;
        end
      end
      S_GCL_RD: state_d = S_GCL_WR;
      S_GCL_WR: begin
        if (!in_alf) begin
          cnt_d     = cnt_q + 6'd1;
          addr_d    = addr_q + 5'd1;
          cap_vld_d = 1'b0;
          state_d   = (addr_q == GC_LAST_ADDR) ? S_CFG : S_GCL_RD;
        end else begin
          cap_vld_d = 1'b1;
        end
      end
      S_CFG: begin
        if (!in_alf) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Rule/mask words 42..57 alternate rule_k, mask_k, i.e. consecutive 104-bit slices.
  always_comb begin
    payload = '0;
    rm_sel  = cnt_q[3:0] - 4'd10;
    rm_base = 11'(rm_sel) * 11'd104;
    if (state_q == S_GCL_WR) begin
      payload = cap_vld_q ? cap_q : in_gc_q;
    end else begin
      case (cnt_q)
        6'd1: begin
          payload[31:16] = 16'hff01;
          payload[15:12] = 4'h3;
          payload[11:8]  = seq_q;
          payload[7]     = CSUM_FLAG;
        end
        6'd36: begin
          payload[32]   = in_test_stop;
          payload[19:0] = in_slot_cycle;
        end
        6'd37: payload[95:0] = in_tb_cfg[95:0];
        6'd38: payload[95:0] = in_tb_cfg[191:96];
        6'd39: payload[63:0] = in_tb_cfg[255:192];
        6'd40: payload = {4'h0, in_pkt_len[95:84], 4'h0, in_pkt_len[83:72],
                          4'h0, in_pkt_len[71:60], 4'h0, in_pkt_len[59:48],
                          4'h0, in_pkt_len[47:36], 4'h0, in_pkt_len[35:24],
                          4'h0, in_pkt_len[23:12], 4'h0, in_pkt_len[11:0]};
`ifdef CFG_REPORT_CSUM_EN
        CSUM_IDX: payload = csum_q;
`endif
        LAST_IDX: payload[15:0] = in_samp_freq;
        default: begin
          if (cnt_q >= RM_FIRST && cnt_q <= RM_LAST) payload[103:0] = in_rule_mask[rm_base +: 104];
        end
      endcase
    end
  end

  always_comb begin
    wr           = 1'b0;
    out_gc_rd    = 1'b0;
    out_rpt_done = 1'b0;
    case (state_q)
      S_HDR, S_GCL_WR, S_CFG: wr = !in_alf;
      S_GCL_RD:               out_gc_rd = 1'b1;
      S_DONE:                 out_rpt_done = 1'b1;
      default: ;
    endcase
    word_type       = (cnt_q == 6'd0) ? 2'b01 : ((cnt_q == LAST_IDX) ? 2'b10 : 2'b11);
    out_rpt_busy    = (state_q != S_IDLE);
    out_rpt_data_wr = wr;
    out_rpt_data    = wr ? {word_type, 4'h0, payload} : '0;
  end

  assign out_gc_addr = addr_q;

endmodule

// File: tb/tb_cfg_report_gen.sv
// Bench for cfg_report_gen: list-based packet model, RAM model with one-cycle-valid read data.
`timescale 1ns/1ps
module tb_cfg_report_gen;
`ifdef CFG_REPORT_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NW       = 60 + CS;
  localparam int LAT_DONE = 93 + CS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_rpt_req = 1'b0;
  logic [3:0]    in_rpt_seq = '0;
  logic          in_alf = 1'b0;
  logic [133:0]  out_rpt_data;
  logic          out_rpt_data_wr, out_rpt_busy, out_rpt_done, out_gc_rd;
  logic [4:0]    out_gc_addr;
  logic [127:0]  in_gc_q = '0;
  logic          in_test_stop = 1'b0;
  logic [19:0]   in_slot_cycle = '0;
  logic [255:0]  in_tb_cfg = '0;
  logic [95:0]   in_pkt_len = '0;
  logic [1663:0] in_rule_mask = '0;
  logic [15:0]   in_samp_freq = '0;

  always #5 clk = ~clk;

  cfg_report_gen #(.PLATFORM("xilinx"), .GCL_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_rpt_req(in_rpt_req), .in_rpt_seq(in_rpt_seq), .in_alf(in_alf),
    .out_rpt_data(out_rpt_data), .out_rpt_data_wr(out_rpt_data_wr), .out_rpt_busy(out_rpt_busy),
    .out_rpt_done(out_rpt_done), .out_gc_rd(out_gc_rd), .out_gc_addr(out_gc_addr),
    .in_gc_q(in_gc_q), .in_test_stop(in_test_stop), .in_slot_cycle(in_slot_cycle),
    .in_tb_cfg(in_tb_cfg), .in_pkt_len(in_pkt_len), .in_rule_mask(in_rule_mask),
    .in_samp_freq(in_samp_freq)
  );

  // GCL RAM: data valid only the cycle after a read, garbage otherwise.
  logic [127:0] mem [32];
  always @(posedge clk)
    in_gc_q <= out_gc_rd ? mem[out_gc_addr] : {$urandom(), $urandom(), $urandom(), $urandom()};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  logic [133:0] got[$];
  logic [133:0] got1[$];
  int done_cnt = 0, done_cyc = 0, first_wr_cyc = 0, alf_viol = 0;
  always @(negedge clk) begin
    if (out_rpt_data_wr) begin
      if (got.size() == 0) first_wr_cyc <= cyc;
      got.push_back(out_rpt_data);
      if (in_alf) alf_viol <= alf_viol + 1;
    end
    if (out_rpt_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Config model, held as fields
  logic [15:0]  tb_size [8];
  logic [15:0]  tb_rate [8];
  logic [11:0]  plen [8];
  logic [103:0] rule [8];
  logic [103:0] mask [8];
  logic [15:0]  sfreq;
  logic         tstop;
  logic [19:0]  slot;
  logic [127:0] exp_pay[$];

  int nchk = 0, nerr = 0;
  int req_cyc = 0, done_base = 0;

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [133:0] expw(input int i);
    logic [1:0] t;
    t = (i == 0) ? 2'b01 : ((i == NW - 1) ? 2'b10 : 2'b11);
    return {t, 4'h0, exp_pay[i]};
  endfunction

  task automatic apply_cfg();
    for (int k = 0; k < 8; k++) begin
      in_tb_cfg[32*k +: 32]     = {tb_size[k], tb_rate[k]};
      in_pkt_len[12*k +: 12]    = plen[k];
      in_rule_mask[208*k +: 208] = {mask[k], rule[k]};
    end
    in_test_stop  = tstop;
    in_slot_cycle = slot;
    in_samp_freq  = sfreq;
  endtask

  task automatic random_setup();
    logic [127:0] t;
    for (int n = 0; n < 32; n++) mem[n] = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < 8; k++) begin
      tb_size[k] = 16'($urandom());
      tb_rate[k] = 16'($urandom());
      plen[k]    = 12'($urandom());
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      rule[k] = t[103:0];
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      mask[k] = t[103:0];
    end
    sfreq = 16'($urandom());
    tstop = 1'($urandom());
    slot  = 20'($urandom());
    apply_cfg();
  endtask

  task automatic build_exp(input logic [3:0] seq);
    logic [127:0] w, cs;
    exp_pay.delete();
    exp_pay.push_back('0);
    w = '0; w[31:16] = 16'hff01; w[15:12] = 4'h3; w[11:8] = seq; w[7] = (CS != 0);
    exp_pay.push_back(w);
    exp_pay.push_back('0);
    exp_pay.push_back('0);
    for (int n = 0; n < 32; n++) exp_pay.push_back(mem[n]);
    w = '0; w[32] = tstop; w[19:0] = slot;
    exp_pay.push_back(w);
    for (int g = 0; g < 3; g++) begin
      w = '0;
      for (int t = 0; t < 3; t++)
        if (3*g + t < 8) w[32*t +: 32] = {tb_size[3*g+t], tb_rate[3*g+t]};
      exp_pay.push_back(w);
    end
    w = '0;
    for (int k = 0; k < 8; k++) w[16*k +: 12] = plen[k];
    exp_pay.push_back(w);
    exp_pay.push_back('0);
    for (int k = 0; k < 8; k++) begin
      exp_pay.push_back({24'h0, rule[k]});
      exp_pay.push_back({24'h0, mask[k]});
    end
    exp_pay.push_back('0);
    if (CS != 0) begin
      cs = '0;
      for (int i = 4; i <= 58; i++) cs = cs ^ exp_pay[i];
      exp_pay.push_back(cs);
    end
    w = '0; w[15:0] = sfreq;
    exp_pay.push_back(w);
  endtask

  task automatic check_pkt(input string tag, input logic [133:0] q[$]);
    chk({tag, "_len"}, 134'(q.size()), 134'(NW));
    for (int i = 0; i < NW && i < q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), q[i], expw(i));
  endtask

  task automatic send_req(input logic [3:0] seq);
    @(posedge clk); #1;
    in_rpt_req = 1'b1;
    in_rpt_seq = seq;
    req_cyc    = cyc;
    @(posedge clk); #1;
    in_rpt_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rand_alf, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt != done_base) break;
      if (rand_alf) in_alf = ($urandom_range(0, 3) == 0);
    end
    in_alf = 1'b0;
    chk({tag, "_done_seen"}, 134'(done_cnt - done_base), 134'd1);
  endtask

  task automatic start_pkt(input logic [3:0] seq);
    build_exp(seq);
    got.delete();
    done_base = done_cnt;
    send_req(seq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [3:0]  s;
    bit found;
    for (int n = 0; n < 32; n++) mem[n] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr",   134'(out_rpt_data_wr), 134'd0);
    chk("rst_data", out_rpt_data,          134'd0);
    chk("rst_busy", 134'(out_rpt_busy),    134'd0);
    chk("rst_done", 134'(out_rpt_done),    134'd0);
    chk("rst_rd",   134'(out_gc_rd),       134'd0);
    chk("rst_addr", 134'(out_gc_addr),     134'd0);
    @(negedge clk) rst_n = 1'b1;

    // Nominal packet with directed GC pattern and tb1/pkt_len1 values
    for (int n = 0; n < 32; n++) begin
      v = n + 32'hA5;
      mem[n] = {v, v, v, v};
    end
    random_setup();
    for (int n = 0; n < 32; n++) begin
      v = n + 32'hA5;
      mem[n] = {v, v, v, v};
    end
    tb_size[0] = 16'h7fff; tb_rate[0] = 16'h0010; plen[0] = 12'd1514;
    apply_cfg();
    start_pkt(4'h7);
    wait_done("t1", 1'b0, 300);
    chk("t1_first_wr_lat", 134'(first_wr_cyc - req_cyc), 134'd1);
    chk("t1_done_lat",     134'(done_cyc - req_cyc),     134'(LAT_DONE));
    check_pkt("t1", got);
    chk("t1_md1",     134'(got[1][31:8]),    134'h0ff0137 & 134'hffffff);
    chk("t1_tb1",     134'(got[37][31:0]),   134'h7fff0010);
    chk("t1_plen1",   134'(got[40][11:0]),   134'h5EA);
    chk("t1_tailhdr", 134'(got[NW-1][133:132]), 134'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_done_once", 134'(done_cnt - done_base), 134'd1);
    chk("t1_idle_busy", 134'(out_rpt_busy), 134'd0);

    // Directed stalls: 5 cycles on GC addr 10 and 5 cycles on word 45
    random_setup();
    start_pkt(4'hB);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      found = out_gc_rd && (out_gc_addr == 5'd10);
    end
    chk("t3_found_gc10", 134'(found), 134'd1);
    @(posedge clk); #1;
    in_alf = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_alf = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      found = (got.size() == 45);
    end
    chk("t3_found_w45", 134'(found), 134'd1);
    in_alf = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_alf = 1'b0;
    wait_done("t3", 1'b0, 300);
    chk("t3_done_lat", 134'(done_cyc - req_cyc), 134'(LAT_DONE + 10));
    check_pkt("t3", got);
    chk("t3_alf_viol", 134'(alf_viol), 134'd0);

    // Random config, random almost-full
    for (int r = 0; r < 3; r++) begin
      random_setup();
      s = 4'($urandom());
      start_pkt(s);
      wait_done($sformatf("rnd%0d", r), 1'b1, 800);
      check_pkt($sformatf("rnd%0d", r), got);
      chk($sformatf("rnd%0d_alf_viol", r), 134'(alf_viol), 134'd0);
    end

    // Requests while busy and on the done cycle are ignored; the next cycle is accepted
    random_setup();
    start_pkt(4'h2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_rpt_req = 1'b1; in_rpt_seq = 4'h9;
    @(posedge clk); #1;
    in_rpt_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      found = out_rpt_done;
    end
    chk("t4_done_found", 134'(found), 134'd1);
    chk("t4_done_lat", 134'(cyc - req_cyc), 134'(LAT_DONE));
    in_rpt_req = 1'b1; in_rpt_seq = 4'hC;
    got1 = got;
    got.delete();
    check_pkt("t4_first", got1);
    build_exp(4'h5);
    @(posedge clk); #1;
    in_rpt_seq = 4'h5;
    req_cyc    = cyc;
    done_base  = done_cnt;
    @(posedge clk); #1;
    in_rpt_req = 1'b0;
    wait_done("t4b", 1'b0, 300);
    chk("t4b_first_wr_lat", 134'(first_wr_cyc - req_cyc), 134'd1);
    check_pkt("t4b", got);

    // Reset in the middle of a packet
    random_setup();
    start_pkt(4'hE);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      found = out_rpt_data_wr && (out_rpt_data == expw(20));
    end
    chk("t5_found_w20", 134'(found), 134'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wr",   134'(out_rpt_data_wr), 134'd0);
    chk("t5_rst_busy", 134'(out_rpt_busy),    134'd0);
    chk("t5_rst_data", out_rpt_data,          134'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_done", 134'(done_cnt - done_base), 134'd0);
    start_pkt(4'h3);
    wait_done("t5b", 1'b0, 300);
    chk("t5b_done_lat", 134'(done_cyc - req_cyc), 134'(LAT_DONE));
    check_pkt("t5b", got);

`ifdef CFG_REPORT_CSUM_EN
    // Checksum of 32 identical GC words with all other payload zero cancels out
    for (int n = 0; n < 32; n++) mem[n] = 128'h1;
    for (int k = 0; k < 8; k++) begin
      tb_size[k] = '0; tb_rate[k] = '0; plen[k] = '0; rule[k] = '0; mask[k] = '0;
    end
    sfreq = '0; tstop = 1'b0; slot = '0;
    apply_cfg();
    start_pkt(4'h1);
    wait_done("t6", 1'b0, 300);
    check_pkt("t6", got);
    chk("t6_csum",     134'(got[59][127:0]), 134'd0);
    chk("t6_csumflag", 134'(got[1][7]),      134'd1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
